// File: rtl/vx_raster_block_iter.sv
// Walks a rasterizer tile block by block (x fastest), culling blocks that lie
// fully outside any edge and emitting the surviving blocks with their edge values.
`ifndef VX_RASTER_PID_BITS
`define VX_RASTER_PID_BITS 16
`endif
`ifndef VX_RASTER_DIM_BITS
`define VX_RASTER_DIM_BITS 16
`endif
`ifndef RASTER_DATA_BITS
`define RASTER_DATA_BITS 32
`endif

module vx_raster_block_iter #(
    parameter string       INSTANCE_ID   = "",
    parameter int unsigned TILE_LOGSIZE  = 5,
    parameter int unsigned BLOCK_LOGSIZE = 2
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        valid_in,
    output logic                                        ready_in,
    input  logic [`VX_RASTER_PID_BITS-1:0]              pid_in,
    input  logic [`VX_RASTER_DIM_BITS-1:0]              xloc_in,
    input  logic [`VX_RASTER_DIM_BITS-1:0]              yloc_in,
    input  logic [2:0][2:0][`RASTER_DATA_BITS-1:0]      edges_in,
    output logic                                        valid_out,
    input  logic                                        ready_out,
    output logic [`VX_RASTER_PID_BITS-1:0]              pid_out,
    output logic [`VX_RASTER_DIM_BITS-1:0]              xloc_out,
    output logic [`VX_RASTER_DIM_BITS-1:0]              yloc_out,
    output logic [2:0][2:0][`RASTER_DATA_BITS-1:0]      edges_out,
    output logic                                        busy
);
    localparam int unsigned PW = `VX_RASTER_PID_BITS;
    localparam int unsigned DW = `VX_RASTER_DIM_BITS;
    localparam int unsigned EW = `RASTER_DATA_BITS;
    localparam int unsigned CW = TILE_LOGSIZE - BLOCK_LOGSIZE;

    if (BLOCK_LOGSIZE == 0 || BLOCK_LOGSIZE >= TILE_LOGSIZE) begin : g_bad_cfg
        $error("%s: need 0 < BLOCK_LOGSIZE < TILE_LOGSIZE", INSTANCE_ID);
    end

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     bx, bx_n;
    logic [CW-1:0]     by, by_n;

    logic [PW-1:0]         pid_r;
    logic [DW-1:0]         xloc_r;
    logic [DW-1:0]         yloc_r;
    logic [2:0][EW-1:0]    a_r;
    logic [2:0][EW-1:0]    b_r;
    logic [2:0][EW-1:0]    cur_e;
    logic [2:0][EW-1:0]    row_e;
    logic [2:0][EW-1:0]    bound;

    logic fire;
    logic reject;
    logic advance;

    // Largest increase an edge gains across a block: max(v,0) * (S-1).
    function automatic logic [EW-1:0] pos_span(input logic [EW-1:0] v);
        return v[EW-1] ? '0 : (v << BLOCK_LOGSIZE) - v;
    endfunction

    // Block is culled when even its most favourable corner is outside an edge.
    always_comb begin
        reject = 1'b0;
        bound  = '0;
        for (int i = 0; i < 3; i++) begin
            bound[i] = cur_e[i] + pos_span(a_r[i]) + pos_span(b_r[i]);
            if (bound[i][EW-1]) begin
                reject = 1'b1;
            end
        end
    end

    assign fire      = (state == IDLE) && valid_in;
    assign valid_out = (state == WALK) && !reject;
    assign advance   = (state == WALK) && (reject || ready_out);
    assign ready_in  = (state == IDLE);
    assign busy      = (state == WALK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            bx    <= '0;
            by    <= '0;
        end else begin
            state <= state_n;
            bx    <= bx_n;
            by    <= by_n;
        end
    end

    always_comb begin
        state_n = state;
        bx_n    = bx;
        by_n    = by;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    state_n = WALK;
                    bx_n    = '0;
                    by_n    = '0;
                end
            end
            WALK: begin
                if (advance) begin
                    if (&bx) begin
                        bx_n = '0;
                        if (&by) begin
                            state_n = IDLE;
                        end else begin
                            by_n = by + CW'(1);
                        end
                    end else begin
                        bx_n = bx + CW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Item and incremental edge values; only meaningful while walking.
    always_ff @(posedge clk) begin
        if (fire) begin
            pid_r  <= pid_in;
            xloc_r <= xloc_in;
            yloc_r <= yloc_in;
            for (int i = 0; i < 3; i++) begin
                a_r[i]   <= edges_in[i][0];
                b_r[i]   <= edges_in[i][1];
                cur_e[i] <= edges_in[i][2];
                row_e[i] <= edges_in[i][2];
            end
        end else if (advance) begin
            for (int i = 0; i < 3; i++) begin
                if (&bx) begin
                    row_e[i] <= row_e[i] + (b_r[i] << BLOCK_LOGSIZE);
                    cur_e[i] <= row_e[i] + (b_r[i] << BLOCK_LOGSIZE);
                end else begin
                    cur_e[i] <= cur_e[i] + (a_r[i] << BLOCK_LOGSIZE);
                end
            end
        end
    end

    assign pid_out  = pid_r;
    assign xloc_out = xloc_r + (DW'(bx) << BLOCK_LOGSIZE);
    assign yloc_out = yloc_r + (DW'(by) << BLOCK_LOGSIZE);

    always_comb begin
        edges_out = '0;
        for (int i = 0; i < 3; i++) begin
            edges_out[i][0] = a_r[i];
            edges_out[i][1] = b_r[i];
            edges_out[i][2] = cur_e[i];
        end
    end

endmodule

// File: tb/tb_vx_raster_block_iter.sv
// Randomized and directed bench for vx_raster_block_iter (TILE_LOGSIZE=3, BLOCK_LOGSIZE=1).
`ifndef VX_RASTER_PID_BITS
`define VX_RASTER_PID_BITS 16
`endif
`ifndef VX_RASTER_DIM_BITS
`define VX_RASTER_DIM_BITS 16
`endif
`ifndef RASTER_DATA_BITS
`define RASTER_DATA_BITS 32
`endif

module tb_vx_raster_block_iter;
    localparam int PW = `VX_RASTER_PID_BITS;
    localparam int DW = `VX_RASTER_DIM_BITS;
    localparam int EW = `RASTER_DATA_BITS;
    localparam int TL = 3;
    localparam int BL = 1;
    localparam int S  = 1 << BL;
    localparam int NB = 1 << (TL - BL);

    typedef logic [2:0][2:0][EW-1:0] edges_t;
    typedef struct {
        logic [PW-1:0] pid;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        edges_t        e;
        bit            acc;
        int            cyc;
    } blk_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          valid_in = 1'b0;
    logic          ready_in;
    logic [PW-1:0] pid_in = '0;
    logic [DW-1:0] xloc_in = '0;
    logic [DW-1:0] yloc_in = '0;
    edges_t        edges_in = '0;
    logic          valid_out;
    logic          ready_out = 1'b1;
    logic [PW-1:0] pid_out;
    logic [DW-1:0] xloc_out;
    logic [DW-1:0] yloc_out;
    edges_t        edges_out;
    logic          busy;

    int   checks = 0;
    int   failures = 0;
    blk_t obs[$];
    blk_t acc_q[$];
    blk_t exp_q[$];
    int   walk_cycles;
    int   stall_seen;
    bit   timed_out;

    vx_raster_block_iter #(
        .INSTANCE_ID   ("tb"),
        .TILE_LOGSIZE  (TL),
        .BLOCK_LOGSIZE (BL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .pid_in    (pid_in),
        .xloc_in   (xloc_in),
        .yloc_in   (yloc_in),
        .edges_in  (edges_in),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .pid_out   (pid_out),
        .xloc_out  (xloc_out),
        .yloc_out  (yloc_out),
        .edges_out (edges_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout sim time exceeded, required finish");
        $fatal(1, "timeout");
    end

    function automatic edges_t mk_edges(input int a0, input int b0, input int c0,
                                        input int a1, input int b1, input int c1,
                                        input int a2, input int b2, input int c2);
        edges_t e;
        e[0][0] = EW'(a0); e[0][1] = EW'(b0); e[0][2] = EW'(c0);
        e[1][0] = EW'(a1); e[1][1] = EW'(b1); e[1][2] = EW'(c1);
        e[2][0] = EW'(a2); e[2][1] = EW'(b2); e[2][2] = EW'(c2);
        return e;
    endfunction

    // Reference: enumerate every block of the tile directly from its coordinates.
    function automatic void build_expected(input logic [PW-1:0] pid, input logic [DW-1:0] x,
                                           input logic [DW-1:0] y, input edges_t e);
        exp_q.delete();
        for (int by = 0; by < NB; by++) begin
            for (int bx = 0; bx < NB; bx++) begin
                blk_t   b;
                bit     rej = 0;
                b.pid = pid;
                b.x   = x + DW'(bx * S);
                b.y   = y + DW'(by * S);
                b.acc = 1;
                b.cyc = 0;
                for (int i = 0; i < 3; i++) begin
                    int     a  = $signed(e[i][0]);
                    int     bb = $signed(e[i][1]);
                    int     c  = $signed(e[i][2]);
                    int     v  = c + a * bx * S + bb * by * S;
                    longint t  = longint'(v) + longint'(a > 0 ? a : 0) * (S - 1)
                               + longint'(bb > 0 ? bb : 0) * (S - 1);
                    int     tt = int'(t);
                    if (tt < 0) rej = 1;
                    b.e[i][0] = e[i][0];
                    b.e[i][1] = e[i][1];
                    b.e[i][2] = EW'(v);
                end
                if (!rej) exp_q.push_back(b);
            end
        end
    endfunction

    function automatic void split_accepted();
        acc_q.delete();
        foreach (obs[k]) if (obs[k].acc) acc_q.push_back(obs[k]);
    endfunction

    // Drives one item and records every valid cycle until the walk ends.
    task automatic run_item(input logic [PW-1:0] pid, input logic [DW-1:0] x,
                            input logic [DW-1:0] y, input edges_t e,
                            input int stall_idx, input int stall_len, input bit rand_ready);
        int nacc = 0;
        int scnt = 0;
        int cyc = 0;
        obs.delete();
        stall_seen = 0;
        timed_out = 0;
        pid_in = pid; xloc_in = x; yloc_in = y; edges_in = e;
        valid_in = 1; ready_out = 1;
        @(posedge clk); #1;
        valid_in = 0;
        pid_in = PW'($urandom); xloc_in = DW'($urandom); edges_in = {9{EW'($urandom)}};
        while (busy === 1'b1) begin
            if (cyc >= 200) begin
                timed_out = 1;
                break;
            end
            if (stall_len > 0 && nacc == stall_idx && scnt < stall_len) begin
                ready_out = 0;
                scnt++;
            end else if (rand_ready) begin
                ready_out = ($urandom_range(0, 2) != 0);
            end else begin
                ready_out = 1;
            end
            if (valid_out === 1'b1) begin
                obs.push_back('{pid_out, xloc_out, yloc_out, edges_out, ready_out, cyc});
                if (ready_out) nacc++;
                else stall_seen++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        ready_out = 1;
        walk_cycles = cyc;
        split_accepted();
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ready_in !== 1'b1 || busy !== 1'b0 || valid_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_state ready_in=%b busy=%b valid_out=%b required 1 0 0",
                     ready_in, busy, valid_out);
        end
        reset = 1;
    endtask

    task automatic test_trivial();
        edges_t e = mk_edges(0, 0, 1, 0, 0, 1, 0, 0, 1);
        build_expected(16'h0011, 16'd16, 16'd8, e);
        run_item(16'h0011, 16'd16, 16'd8, e, -1, 0, 0);
        checks++;
        if (timed_out || acc_q.size() != 16) begin
            failures++;
            $display("FAIL trivial_count got=%0d required=16 timeout=%0d", acc_q.size(), timed_out);
        end
        checks++;
        if (acc_q.size() > 0 && acc_q[0].cyc != 0) begin
            failures++;
            $display("FAIL trivial_latency first output cycle=%0d required=0", acc_q[0].cyc);
        end
        for (int k = 0; k < exp_q.size() && k < acc_q.size(); k++) begin
            checks++;
            if (acc_q[k].pid !== exp_q[k].pid || acc_q[k].x !== exp_q[k].x ||
                acc_q[k].y !== exp_q[k].y || acc_q[k].e !== exp_q[k].e || acc_q[k].cyc != k) begin
                failures++;
                $display("FAIL trivial_blk%0d got x=%0d y=%0d cyc=%0d required x=%0d y=%0d cyc=%0d",
                         k, acc_q[k].x, acc_q[k].y, acc_q[k].cyc, exp_q[k].x, exp_q[k].y, k);
            end
        end
        checks++;
        if (walk_cycles != 16 || ready_in !== 1'b1) begin
            failures++;
            $display("FAIL trivial_end walk=%0d ready_in=%b required 16 1", walk_cycles, ready_in);
        end
    endtask

    task automatic test_partial();
        edges_t e = mk_edges(1, 0, -3, 0, 0, 1, 0, 0, 1);
        build_expected(16'h0022, 16'd16, 16'd8, e);
        run_item(16'h0022, 16'd16, 16'd8, e, -1, 0, 0);
        checks++;
        if (acc_q.size() != 12 || exp_q.size() != 12) begin
            failures++;
            $display("FAIL partial_count got=%0d required=12", acc_q.size());
        end
        checks++;
        if (acc_q.size() > 0 && (acc_q[0].x !== 16'd18 || $signed(acc_q[0].e[0][2]) != -1)) begin
            failures++;
            $display("FAIL partial_first got x=%0d e0=%0d required x=18 e0=-1",
                     acc_q[0].x, $signed(acc_q[0].e[0][2]));
        end
        for (int k = 0; k < exp_q.size() && k < acc_q.size(); k++) begin
            checks++;
            if (acc_q[k].x !== exp_q[k].x || acc_q[k].y !== exp_q[k].y || acc_q[k].e !== exp_q[k].e) begin
                failures++;
                $display("FAIL partial_blk%0d got x=%0d y=%0d e0=%0d required x=%0d y=%0d e0=%0d",
                         k, acc_q[k].x, acc_q[k].y, $signed(acc_q[k].e[0][2]),
                         exp_q[k].x, exp_q[k].y, $signed(exp_q[k].e[0][2]));
            end
        end
        checks++;
        if (walk_cycles != 16) begin
            failures++;
            $display("FAIL partial_walk got=%0d required=16", walk_cycles);
        end
    endtask

    task automatic test_full_reject();
        edges_t e = mk_edges(0, 0, -100, 0, 0, -100, 0, 0, -100);
        run_item(16'h0033, 16'd0, 16'd0, e, -1, 0, 0);
        checks++;
        if (obs.size() != 0) begin
            failures++;
            $display("FAIL full_reject_outputs got=%0d required=0", obs.size());
        end
        checks++;
        if (walk_cycles != 16 || ready_in !== 1'b1) begin
            failures++;
            $display("FAIL full_reject_walk got=%0d ready_in=%b required 16 1", walk_cycles, ready_in);
        end
    endtask

    task automatic test_backpressure();
        edges_t e = mk_edges(0, 0, 1, 0, 0, 1, 0, 0, 1);
        int held = 0;
        build_expected(16'h0044, 16'd16, 16'd8, e);
        run_item(16'h0044, 16'd16, 16'd8, e, 3, 5, 0);
        checks++;
        if (acc_q.size() != 16) begin
            failures++;
            $display("FAIL bp_count got=%0d required=16", acc_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < acc_q.size(); k++) begin
            checks++;
            if (acc_q[k].x !== exp_q[k].x || acc_q[k].y !== exp_q[k].y || acc_q[k].e !== exp_q[k].e) begin
                failures++;
                $display("FAIL bp_blk%0d got x=%0d y=%0d required x=%0d y=%0d",
                         k, acc_q[k].x, acc_q[k].y, exp_q[k].x, exp_q[k].y);
            end
        end
        foreach (obs[k]) begin
            if (!obs[k].acc) begin
                held++;
                checks++;
                if (obs[k].x !== exp_q[3].x || obs[k].y !== exp_q[3].y ||
                    obs[k].e !== exp_q[3].e || obs[k].pid !== exp_q[3].pid) begin
                    failures++;
                    $display("FAIL bp_hold got x=%0d y=%0d required x=%0d y=%0d",
                             obs[k].x, obs[k].y, exp_q[3].x, exp_q[3].y);
                end
            end
        end
        checks++;
        if (held != 5 || walk_cycles != 21) begin
            failures++;
            $display("FAIL bp_stall held=%0d walk=%0d required 5 21", held, walk_cycles);
        end
    endtask

    task automatic test_row_step();
        edges_t e = mk_edges(0, 3, 0, 0, 0, 1, 0, 0, 1);
        build_expected(16'h0055, 16'd40, 16'd64, e);
        run_item(16'h0055, 16'd40, 16'd64, e, -1, 0, 0);
        checks++;
        if (acc_q.size() != 16) begin
            failures++;
            $display("FAIL row_count got=%0d required=16", acc_q.size());
        end
        for (int r = 0; r < NB && r * NB < acc_q.size(); r++) begin
            checks++;
            if ($signed(acc_q[r * NB].e[0][2]) != r * 6 || acc_q[r * NB].y !== 16'(64 + 2 * r)) begin
                failures++;
                $display("FAIL row%0d got e0=%0d y=%0d required e0=%0d y=%0d",
                         r, $signed(acc_q[r * NB].e[0][2]), acc_q[r * NB].y, r * 6, 64 + 2 * r);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            edges_t        e;
            logic [PW-1:0] pid = PW'($urandom);
            logic [DW-1:0] x = (it % 2) ? DW'(16'hFFFA) : DW'($urandom);
            logic [DW-1:0] y = DW'($urandom);
            int            errs = 0;
            for (int i = 0; i < 3; i++) begin
                e[i][0] = EW'($urandom_range(0, 16) - 8);
                e[i][1] = EW'($urandom_range(0, 16) - 8);
                e[i][2] = EW'($urandom_range(0, 60) - 30);
            end
            build_expected(pid, x, y, e);
            run_item(pid, x, y, e, -1, 0, 1);
            checks++;
            if (acc_q.size() != exp_q.size() || timed_out) begin
                failures++;
                $display("FAIL rand%0d_count got=%0d required=%0d", it, acc_q.size(), exp_q.size());
            end
            for (int k = 0; k < exp_q.size() && k < acc_q.size(); k++) begin
                if (acc_q[k].pid !== exp_q[k].pid || acc_q[k].x !== exp_q[k].x ||
                    acc_q[k].y !== exp_q[k].y || acc_q[k].e !== exp_q[k].e) errs++;
            end
            checks++;
            if (errs != 0) begin
                failures++;
                $display("FAIL rand%0d_content mismatched=%0d required=0", it, errs);
            end
            checks++;
            if (walk_cycles != 16 + stall_seen) begin
                failures++;
                $display("FAIL rand%0d_walk got=%0d required=%0d", it, walk_cycles, 16 + stall_seen);
            end
        end
    endtask

    task automatic test_reset_midwalk();
        edges_t e = mk_edges(0, 0, 1, 0, 0, 1, 0, 0, 1);
        int n = 0;
        int cyc = 0;
        pid_in = 16'h0066; xloc_in = 16'd16; yloc_in = 16'd8; edges_in = e;
        valid_in = 1; ready_out = 1;
        @(posedge clk); #1;
        valid_in = 0;
        while (n < 5 && cyc < 50) begin
            if (valid_out === 1'b1) n++;
            cyc++;
            @(posedge clk); #1;
        end
        #2 reset = 0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || ready_in !== 1'b1 || busy !== 1'b0 || n != 5) begin
            failures++;
            $display("FAIL midwalk_reset valid_out=%b ready_in=%b busy=%b n=%0d required 0 1 0 5",
                     valid_out, ready_in, busy, n);
        end
        @(posedge clk); #1;
        reset = 1;
        build_expected(16'h0077, 16'd100, 16'd200, e);
        run_item(16'h0077, 16'd100, 16'd200, e, -1, 0, 0);
        checks++;
        if (acc_q.size() != 16 || (acc_q.size() > 0 &&
            (acc_q[0].x !== 16'd100 || acc_q[0].y !== 16'd200 || acc_q[0].pid !== 16'h0077))) begin
            failures++;
            $display("FAIL midwalk_restart count=%0d required=16 first at 100,200", acc_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_trivial();
        test_partial();
        test_full_reject();
        test_backpressure();
        test_row_step();
        test_random();
        test_reset_midwalk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vx_raster_block_iter.md
VX_RASTER_BLOCK_ITER -- requirements
Module: VX_raster_block_iter

Interface
REQ-001 SHALL have parameter INSTANCE_ID, default "", trace label.
REQ-002 SHALL have parameter TILE_LOGSIZE, default 5, log2 of tile edge in pixels.
REQ-003 SHALL have parameter BLOCK_LOGSIZE, default 2, log2 of block edge in pixels; SHALL satisfy 0 < BLOCK_LOGSIZE < TILE_LOGSIZE.
REQ-004 SHALL have one clock, clk, with all state sampled on its rising edge.
REQ-005 SHALL have reset, input, 1 bit; reset is asynchronous and active-low.
REQ-006 SHALL have valid_in, input, 1: primitive/tile item valid.
REQ-007 SHALL have ready_in, output, 1: item accepted when valid_in && ready_in.
REQ-008 SHALL have pid_in, input, `VX_RASTER_PID_BITS: primitive id.
REQ-009 SHALL have xloc_in and yloc_in, input, `VX_RASTER_DIM_BITS each: tile origin in pixels.
REQ-010 SHALL have edges_in, input, [2:0][2:0]`RASTER_DATA_BITS: per edge i, {a,b,c} = [i][0],[i][1],[i][2], signed; c is the edge value at the tile origin.
REQ-011 SHALL have valid_out, output, 1, and ready_out, input, 1: block handshake.
REQ-012 SHALL have pid_out, xloc_out, yloc_out and edges_out, outputs, same widths as the inputs: block id, block origin and edges; [i][2] is the value at the block origin.
REQ-013 SHALL have busy, output, 1: high while an item is being walked.

Function
REQ-014 SHALL implement two states, IDLE and WALK; ready_in = (state==IDLE).
REQ-015 On an input fire, SHALL latch the item, zero the block counters bx and by (each TILE_LOGSIZE-BLOCK_LOGSIZE bits), set cur_e[i] = row_e[i] = c_i, and enter WALK.
REQ-016 In WALK, SHALL evaluate the block at (bx,by); with S=2^BLOCK_LOGSIZE, the block is rejected if any edge has cur_e[i] + max(a_i,0)*(S-1) + max(b_i,0)*(S-1) < 0 (signed compare).
REQ-017 SHALL drive valid_out = (state==WALK) && ~reject, combinationally from registered state only, with no dependency on ready_out.
REQ-018 Outputs SHALL be xloc_out = xloc + (bx<<BLOCK_LOGSIZE), yloc_out = yloc + (by<<BLOCK_LOGSIZE), pid_out = pid, edges_out[i] = {a_i, b_i, cur_e[i]}.
REQ-019 SHALL advance when reject is true or (valid_out && ready_out): each advance costs 1 cycle, including rejected blocks.
REQ-020 The block walk order SHALL be x fastest, then y.
REQ-021 Advance within a row: bx+1; cur_e += a<<BLOCK_LOGSIZE.
REQ-022 Advance at row end (bx max): bx=0, by+1; row_e += b<<BLOCK_LOGSIZE; cur_e = new row_e.
REQ-023 Advance on the last block (bx and by max) SHALL return to IDLE; a new item is accepted no earlier than the following cycle.
REQ-024 All edge arithmetic SHALL be modulo 2^`RASTER_DATA_BITS; dim additions SHALL wrap at `VX_RASTER_DIM_BITS.
REQ-025 While valid_out && ~ready_out, all outputs SHALL hold stable.
REQ-026 Latency: input fire in cycle N gives the first block evaluated in cycle N+1.
REQ-027 If all blocks are rejected, SHALL produce no output and remain in WALK for exactly 4^(TILE_LOGSIZE-BLOCK_LOGSIZE) cycles.
REQ-028 busy = (state==WALK).

Reset
REQ-029 On reset assertion, SHALL immediately force state=IDLE, valid_out=0, busy=0, ready_in=1 and bx=by=0, including in the middle of a walk; the in-flight item is discarded.
REQ-030 Datapath registers (latched item, cur_e, row_e) SHALL need no reset, but outputs SHALL be ignored while valid_out=0.
REQ-031 Release SHALL be synchronized externally; the first input is accepted on the first clock edge after deassertion.

Verification (TILE_LOGSIZE=3, BLOCK_LOGSIZE=1: 16 blocks, S=2)
REQ-032 Trivial accept: tile (16,8), all edges a=0, b=0, c=1, ready_out=1 -> 16 consecutive outputs starting at cycle N+1; x=16,18,20,22 repeating for y=8,10,12,14; every [i][2] = 1; then ready_in=1.
REQ-033 Partial reject: edge0 a=1, b=0, c=-3; edges 1 and 2 a=0, b=0, c=1 -> column dx=0 rejected; 12 outputs at dx=2,4,6 with edge0 value -1,1,3 on each row; the walk lasts 16 cycles.
REQ-034 Full reject: all c=-100, a=b=0 -> no valid_out; busy high for 16 cycles; ready_in high in cycle N+17.
REQ-035 Backpressure: case REQ-032 with ready_out low for 5 cycles while block 3 is presented -> block 3 outputs held stable; no block is lost or duplicated; total 16 outputs.
REQ-036 Row stepping: a=0, b=3, c=0 on edge0 -> rows by=0..3 output edge0 value 0,6,12,18.
REQ-037 Reset mid-walk: assert reset after 5 outputs -> valid_out=0 and ready_in=1 asynchronously; a new item after release walks from block 0.
